// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply, restoring divide, sign fix-up.
// Optional signed MULT/DIV support is enabled by defining MULDIV_SIGNED_EN.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iStart,
  input  logic [1:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iMTHI,
  input  logic             iMTLO,
  input  logic [WIDTH-1:0] iWData,
  output logic [WIDTH-1:0] oHI,
  output logic [WIDTH-1:0] oLO,
  output logic             oBusy,
  output logic             oDone
);

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 is_div_q, is_div_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem, dividend;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       r;
  logic [WIDTH+1:0]     trial;

`ifdef MULDIV_SIGNED_EN
  logic neg_a_q, neg_a_d;
  logic neg_b_q, neg_b_d;
  logic signed_op;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

`ifdef MULDIV_SIGNED_EN
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    signed_op = ~iOp[0];
    mag_a     = (signed_op && iA[WIDTH-1]) ? -iA : iA;
    mag_b     = (signed_op && iB[WIDTH-1]) ? -iB : iB;
    prod      = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo       = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // Remainder follows the dividend's sign.
    rem       = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    dividend  = neg_a_q ? -opa_q : opa_q;
`else
    mag_a     = iA;
    mag_b     = iB;
    prod      = acc_q;
    quo       = acc_q[WIDTH-1:0];
    rem       = acc_q[2*WIDTH-1:WIDTH];
    dividend  = opa_q;
`endif

    // Multiply step: conditionally add multiplicand to the upper half, then shift right.
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    // Divide step: shift the next dividend bit into the partial remainder and trial-subtract.
    r     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial = {1'b0, r} - {2'b00, opb_q};

    unique case (state_q)
      StIdle: begin
        if (iStart) begin
          cnt_d    = '0;
          opa_d    = mag_a;
          opb_d    = mag_b;
          acc_d    = {{WIDTH{1'b0}}, (iOp[1] ? mag_a : mag_b)};
          is_div_d = iOp[1];
`ifdef MULDIV_SIGNED_EN
          neg_a_d  = signed_op & iA[WIDTH-1];
          neg_b_d  = signed_op & iB[WIDTH-1];
`endif
          state_d  = iOp[1] ? StDiv : StMul;
        end else begin
          if (iMTHI) hi_d = iWData;
          if (iMTLO) lo_d = iWData;
        end
      end
      StMul: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = StFix;
      end
      StDiv: begin
        if (opb_q == '0) begin
          state_d = StFix;
        end else begin
          if (!trial[WIDTH+1]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                 acc_d = {r[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = StFix;
        end
      end
      StFix: begin
        if (is_div_q) begin
          if (opb_q == '0) begin
            lo_d = '1;
            hi_d = dividend;
          end else begin
            lo_d = quo;
            hi_d = rem;
          end
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StMul) || (state_d == StDiv) || (state_d == StFix);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MULDIV_SIGNED_EN
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
`endif
    end
  end

  assign oHI   = hi_q;
  assign oLO   = lo_q;
  assign oBusy = busy_q;
  assign oDone = done_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed corners plus random operations against an arithmetic model.
module tb_muldiv_sequencer;

  logic        iCLK;
  logic        iRST_n;
  logic        iStart;
  logic [1:0]  iOp;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        iMTHI;
  logic        iMTLO;
  logic [31:0] iWData;
  logic [31:0] oHI;
  logic [31:0] oLO;
  logic        oBusy;
  logic        oDone;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .iCLK   (iCLK),
    .iRST_n (iRST_n),
    .iStart (iStart),
    .iOp    (iOp),
    .iA     (iA),
    .iB     (iB),
    .iMTHI  (iMTHI),
    .iMTLO  (iMTLO),
    .iWData (iWData),
    .oHI    (oHI),
    .oLO    (oLO),
    .oBusy  (oBusy),
    .oDone  (oDone)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Plain-arithmetic reference: signed ops use 64-bit integer math (C-style truncation).
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    bit          sgn;
    longint      sa, sb;
    logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
    sgn = ~op[0];
`else
    sgn = 1'b0;
`endif
    if (!op[1]) begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
      end else begin
        p = {32'b0, a} * {32'b0, b};
      end
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lo = 32'(sa / sb);
      hi = 32'(sa % sb);
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int pulse_at, input bit mthi);
    logic [31:0] ehi, elo;
    int k, done_cyc, busy_cnt, exp_lat;
    model(op, a, b, ehi, elo);
    exp_lat = (op[1] && b == 32'd0) ? 3 : 34;
    @(negedge iCLK);
    iStart = 1'b1; iOp = op; iA = a; iB = b;
    if (mthi) begin
      iMTHI  = 1'b1;
      iWData = 32'hA5A5_A5A5;
    end
    @(negedge iCLK);
    iStart = 1'b0; iMTHI = 1'b0;
    iA = $urandom; iB = $urandom;
    check("hold_hi", {32'b0, oHI}, {32'b0, m_hi});
    check("hold_lo", {32'b0, oLO}, {32'b0, m_lo});
    k = 1; done_cyc = 0; busy_cnt = 0;
    while (done_cyc == 0 && k <= 60) begin
      if (oBusy) busy_cnt++;
      if (oDone) begin
        done_cyc = k;
      end else begin
        if (k == pulse_at) begin
          iStart = 1'b1;
          iOp    = 2'($urandom_range(0, 3));
        end else begin
          iStart = 1'b0;
        end
        @(negedge iCLK);
        k++;
      end
    end
    iStart = 1'b0;
    check("done_latency", 64'(done_cyc), 64'(exp_lat));
    check("busy_cycles", 64'(busy_cnt), 64'(exp_lat - 1));
    check("result_hi", {32'b0, oHI}, {32'b0, ehi});
    check("result_lo", {32'b0, oLO}, {32'b0, elo});
    m_hi = ehi;
    m_lo = elo;
    @(negedge iCLK);
    check("done_single", {63'b0, oDone}, 64'd0);
    check("idle_busy", {63'b0, oBusy}, 64'd0);
  endtask

  task automatic move(input bit hi_en, input bit lo_en, input logic [31:0] data);
    @(negedge iCLK);
    iMTHI = hi_en; iMTLO = lo_en; iWData = data;
    @(negedge iCLK);
    iMTHI = 1'b0; iMTLO = 1'b0;
    if (hi_en) m_hi = data;
    if (lo_en) m_lo = data;
    check("move_hi", {32'b0, oHI}, {32'b0, m_hi});
    check("move_lo", {32'b0, oLO}, {32'b0, m_lo});
  endtask

  initial begin
    int dones;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    iRST_n = 1'b0; iStart = 1'b0; iOp = '0; iA = '0; iB = '0;
    iMTHI = 1'b0; iMTLO = 1'b0; iWData = '0;
    #12;
    check("rst_busy", {63'b0, oBusy}, 64'd0);
    check("rst_done", {63'b0, oDone}, 64'd0);
    check("rst_hi", {32'b0, oHI}, 64'd0);
    check("rst_lo", {32'b0, oLO}, 64'd0);
    @(negedge iCLK);
    iRST_n = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    check("multu_max_hi", {32'b0, oHI}, 64'hFFFF_FFFE);
    check("multu_max_lo", {32'b0, oLO}, 64'h0000_0001);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(2'b11, 32'h0000_1234, 32'd0, 0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'd0, 0, 1'b0);
    run_op(2'b00, $urandom, $urandom, 5, 1'b0);
    move(1'b1, 1'b1, 32'h1357_9BDF);
    move(1'b1, 1'b0, 32'h2468_ACE0);
    move(1'b0, 1'b1, 32'h0F0F_F0F0);
    run_op(2'b01, 32'd7, 32'd9, 0, 1'b1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);

    // Reset in the middle of a DIVU.
    @(negedge iCLK);
    iStart = 1'b1; iOp = 2'b11; iA = 32'hDEAD_BEEF; iB = 32'd3;
    @(negedge iCLK);
    iStart = 1'b0;
    repeat (9) @(negedge iCLK);
    iRST_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    check("abort_busy", {63'b0, oBusy}, 64'd0);
    check("abort_done", {63'b0, oDone}, 64'd0);
    check("abort_hi", {32'b0, oHI}, 64'd0);
    check("abort_lo", {32'b0, oLO}, 64'd0);
    repeat (2) @(negedge iCLK);
    iRST_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge iCLK);
      if (oDone) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    run_op(2'b00, 32'd3, 32'hFFFF_FFFE, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 100);
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand, HI and LO width; only 32 is supported.
REQ-002 Parameter: CNT_W, 5, iteration counter width, which is log2(WIDTH).
REQ-003 Port: iCLK  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port: iRST_n  in  1  asynchronous active-low reset.
REQ-005 Port: iStart  in  1  request to begin the operation selected by iOp.
REQ-006 Port: iOp  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 Port: iA  in  WIDTH  multiplicand or dividend, sampled on accept.
REQ-008 Port: iB  in  WIDTH  multiplier or divisor, sampled on accept.
REQ-009 Port: iMTHI  in  1  write iWData to HI.
REQ-010 Port: iMTLO  in  1  write iWData to LO.
REQ-011 Port: iWData  in  WIDTH  MTHI/MTLO write data.
REQ-012 Port: oHI  out  WIDTH  HI register (MFHI source).
REQ-013 Port: oLO  out  WIDTH  LO register (MFLO source).
REQ-014 Port: oBusy  out  1  pipeline stall request.
REQ-015 Port: oDone  out  1  one-cycle completion pulse.

Function
REQ-016 States SHALL be IDLE, MUL, DIV, FIX and DONE, with the counter cleared on every accept.
REQ-017 Accept SHALL occur only when state is IDLE and iStart=1; MUL ops go to MUL, DIV ops go to DIV.
REQ-018 On accept, iA and iB SHALL be latched into internal registers; in signed mode their magnitudes are latched and the operand signs are recorded.
REQ-019 MUL SHALL perform one radix-2 shift-add step per cycle for exactly 32 cycles, then go to FIX.
REQ-020 DIV SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles, then go to FIX.
REQ-021 FIX SHALL apply sign correction in one cycle, write HI and LO, then go to DONE.
REQ-022 DONE SHALL assert oDone for one cycle and return to IDLE.
REQ-023 Latency: accept at edge N; oBusy=1 during cycles N+1..N+33; oDone=1 and oBusy=0 in cycle N+34; oHI and oLO are valid from cycle N+34.
REQ-024 MUL results: HI SHALL hold product[63:32] and LO SHALL hold product[31:0].
REQ-025 DIV results: LO SHALL hold the quotient and HI SHALL hold the remainder.
REQ-026 Signed quotient SHALL truncate toward zero; signed remainder SHALL take the sign of the dividend.
REQ-027 Divide by zero SHALL skip DIV and enter FIX on the cycle after accept, with LO=0xFFFFFFFF and HI=dividend; oDone then falls in cycle N+3.
REQ-028 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0 with normal latency.
REQ-029 iStart while not IDLE SHALL be ignored, with no queuing.
REQ-030 iMTHI or iMTLO SHALL write only when state is IDLE and iStart=0.
REQ-031 If iStart and a move arrive together in IDLE, the start SHALL win and the move SHALL be dropped.
REQ-032 iMTHI and iMTLO asserted together SHALL write iWData to both registers.
REQ-033 HI and LO SHALL hold their previous values from accept until the FIX write.

Reset
REQ-034 While iRST_n=0: state SHALL be IDLE, the counter 0, oHI=0, oLO=0, oBusy=0, oDone=0, and all internal operand and accumulator registers 0.
REQ-035 Reset mid-operation SHALL abort immediately without writing HI or LO; the first accept after release SHALL behave as from power-up.

Configuration
REQ-036 Macro MULDIV_SIGNED_EN defined: MULT and DIV SHALL be signed as specified in REQ-018, REQ-026 and REQ-028.
REQ-037 Macro MULDIV_SIGNED_EN undefined: MULT SHALL equal MULTU and DIV SHALL equal DIVU; FIX is still traversed, so latency is unchanged; the sign logic is absent.

Verification
REQ-038 Reset, then MULTU with A=0xFFFFFFFF and B=0xFFFFFFFF -> oDone at N+34, HI=0xFFFFFFFE, LO=0x00000001, oBusy high for 33 cycles.
REQ-039 SIGNED_EN, DIV with A=-7 and B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); without the macro the same stimulus gives LO=0x7FFFFFFC, HI=0x00000001.
REQ-040 DIVU with A=0x1234 and B=0 -> oDone at N+3, LO=0xFFFFFFFF, HI=0x00001234.
REQ-041 iStart pulsed at N+5 during a MULT -> ignored, a single oDone, result unchanged; then iMTHI with iWData=0xA5A5A5A5 together with iStart in IDLE -> the start proceeds and HI is not written by the move.
REQ-042 iRST_n low at N+10 of a DIVU -> immediate oBusy=0, oHI=0, oLO=0, no oDone; a fresh MULT with A=3 and B=-2 after release -> HI=0xFFFFFFFF, LO=0xFFFFFFFA (SIGNED_EN).
REQ-043 SIGNED_EN, DIV with A=0x80000000 and B=0xFFFFFFFF -> LO=0x80000000, HI=0, oDone at N+34.
